image_bram_arb: RTL and testbench

Read-port arbiter for the 320x240 RGB444 image BRAM (17-bit address, 12-bit data, 76 800 words). It shares the single synchronous read port between two requesters:
- **Display path**: the VGA pixel fetch, which has priority and a fixed latency.
- **Host path**: an image-processing or UART readback engine, served in idle cycles through a req/ack handshake.

It sits between the VGA timing/fetch logic and `image_bram`, and owns the BRAM address bus exclusively.

---
 rtl/image_bram_arb.sv | 166 ++++++++++++++++
 tb/tb_image_bram_arb.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/image_bram_arb.sv
// image_bram_arb
//
// Read-port arbiter for the 320x240 RGB444 image BRAM. The display fetch
// and a host engine (image processing / UART readback) share the single
// synchronous read port. The display path has priority. The host path uses
// a req/ack handshake and is served in cycles the display leaves idle. Both
// paths see a fixed 2-cycle latency from the request edge to the data edge.
//
// Optional build macro: IMAGE_BRAM_ARB_STARVE_GUARD_EN
//   defined   : a host wait counter forces a host slot after STARVE_LIM
//               waiting cycles. The display slot taken this way returns the
//               last display pixel with disp_miss set.
//   undefined : display has absolute priority and disp_miss is tied 0.
//
// Ports
//   clk, rst_n                 system clock, async active-low reset
//   disp_req, disp_addr        display read request (sampled every cycle)
//   disp_data, disp_valid      display read data and its valid strobe
//   disp_miss                  with disp_valid: slot stolen, data repeated
//   host_req, host_addr        host read request (level, held until ack)
//   host_ack                   one-cycle pulse in the grant cycle
//   host_data, host_valid      host read data and its valid strobe
//   bram_addr                  registered BRAM read address
//   bram_data                  BRAM read data, one cycle after the address
module image_bram_arb #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 12,
    parameter int DEPTH      = 76800,
    parameter int STARVE_LIM = 800
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              disp_miss,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_data,
    output logic              host_valid,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_data
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

    // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    owner_t              grant;
    logic [ADDR_W-1:0]   gnt_addr;
    logic                gnt_zero;
    logic                force_host;

    owner_t              own1, own2;
    logic                zero1, zero2;
    logic [DATA_W-1:0]   rd_data;

    always_comb begin
        grant    = OWN_NONE;
        if (force_host)
            grant = OWN_HOST;
        else if (disp_req)
            grant = OWN_DISP;
        else if (host_req)
            grant = OWN_HOST;
        gnt_addr = (grant == OWN_HOST) ? host_addr : disp_addr;
        gnt_zero = ({1'b0, gnt_addr} >= DEPTH_X);
    end

    // Stage 1 travels with the address, stage 2 with the BRAM read cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_addr <= '0;
            host_ack  <= 1'b0;
            own1      <= OWN_NONE;
            zero1     <= 1'b0;
            own2      <= OWN_NONE;
            zero2     <= 1'b0;
        end else begin
            host_ack <= (grant == OWN_HOST);
            own1     <= grant;
            zero1    <= gnt_zero && (grant != OWN_NONE);
            own2     <= own1;
            zero2    <= zero1;
            // Idle cycles leave the address bus untouched.
            if (grant != OWN_NONE)
                bram_addr <= gnt_zero ? '0 : gnt_addr;
        end
    end

    assign rd_data = zero2 ? '0 : bram_data;

`ifdef IMAGE_BRAM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIM + 1);

    logic [CNT_W-1:0]  wait_cnt;
    logic              miss1, miss2;
    logic [DATA_W-1:0] last_pix;

    // The counter cannot pass STARVE_LIM: reaching it forces the host grant,
    // which clears it on the same edge.
    assign force_host = host_req && (wait_cnt == CNT_W'(STARVE_LIM));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            miss1    <= 1'b0;
            miss2    <= 1'b0;
            last_pix <= '0;
        end else begin
            if (!host_req || grant == OWN_HOST)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + CNT_W'(1);
            // A display request losing to a forced host slot still gets a
            // (repeated) pixel so the VGA stream never loses a beat.
            miss1 <= force_host && disp_req;
            miss2 <= miss1;
            if (own2 == OWN_DISP)
                last_pix <= rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            disp_miss <= 1'b0;
        else
            disp_miss <= miss2;
    end
`else
    assign force_host = 1'b0;
    assign disp_miss  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_data  <= '0;
            disp_valid <= 1'b0;
            host_data  <= '0;
            host_valid <= 1'b0;
        end else begin
            host_valid <= (own2 == OWN_HOST);
            if (own2 == OWN_HOST)
                host_data <= rd_data;
`ifdef IMAGE_BRAM_ARB_STARVE_GUARD_EN
            disp_valid <= (own2 == OWN_DISP) || miss2;
            if (own2 == OWN_DISP)
                disp_data <= rd_data;
            else if (miss2)
                disp_data <= last_pix;
`else
            disp_valid <= (own2 == OWN_DISP);
            if (own2 == OWN_DISP)
                disp_data <= rd_data;
`endif
        end
    end

endmodule

// File: tb/tb_image_bram_arb.sv
// Directed testbench for image_bram_arb. A behavioural BRAM returns
// addr[11:0] one cycle after the address. Inputs change 1 ns after a rising
// edge and outputs are sampled at the same point, so "after edge i" means
// the state registered by the edge that sampled stimulus row i.
module tb_image_bram_arb;
    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 12;
    localparam int DEPTH      = 76800;
    localparam int STARVE_LIM = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              disp_req = 1'b0;
    logic [ADDR_W-1:0] disp_addr = '0;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              disp_miss;
    logic              host_req = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic              host_ack;
    logic [DATA_W-1:0] host_data;
    logic              host_valid;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) bram_data <= bram_addr[11:0];

    image_bram_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data),
        .disp_valid(disp_valid), .disp_miss(disp_miss),
        .host_req(host_req), .host_addr(host_addr), .host_ack(host_ack),
        .host_data(host_data), .host_valid(host_valid),
        .bram_addr(bram_addr), .bram_data(bram_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bram_addr"}, bram_addr, 0);
        check({tag, "_disp_data"}, disp_data, 0);
        check({tag, "_disp_valid"}, disp_valid, 0);
        check({tag, "_disp_miss"}, disp_miss, 0);
        check({tag, "_host_ack"}, host_ack, 0);
        check({tag, "_host_data"}, host_data, 0);
        check({tag, "_host_valid"}, host_valid, 0);
    endtask

    // Consecutive display reads base..base+n-1, then a 3-cycle flush.
    task automatic disp_run(input int base, input int n);
        for (int i = 0; i < n + 3; i++) begin
            disp_req  = (i < n);
            disp_addr = ADDR_W'(base + i);
            step();
            if (i < n) check("sweep_addr", bram_addr, base + i);
            check("sweep_ack", host_ack, 0);
            check("sweep_miss", disp_miss, 0);
            check("sweep_valid", disp_valid, (i >= 2 && i < n + 2));
            if (i >= 2 && i < n + 2)
                check("sweep_data", disp_data, (base + i - 2) & 'hFFF);
        end
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Display sweeps at the start and at the top of the frame buffer.
        disp_run(0, 16);
        disp_run(76784, 16);

        // Host reads during blanking: three back-to-back accepted requests.
        host_addr = 17'h00123;
        for (int i = 0; i < 6; i++) begin
            host_req = (i < 3);
            step();
            check("blank_ack", host_ack, (i < 3));
            check("blank_valid", host_valid, (i >= 2 && i < 5));
            if (i >= 2 && i < 5) check("blank_data", host_data, 'h123);
            check("blank_disp_valid", disp_valid, 0);
        end
        check("idle_hold_addr", bram_addr, 'h123);

`ifndef IMAGE_BRAM_ARB_STARVE_GUARD_EN
        // Contention: display wins for 10 cycles, host gets slot 10.
        host_addr = 17'h000AB;
        for (int i = 0; i < 14; i++) begin
            disp_req  = (i < 10);
            disp_addr = ADDR_W'(32'h200 + i);
            host_req  = (i <= 10);
            step();
            check("cont_ack", host_ack, (i == 10));
            if (i < 10) check("cont_addr", bram_addr, 32'h200 + i);
            if (i == 10) check("cont_host_addr", bram_addr, 'hAB);
            check("cont_disp_valid", disp_valid, (i >= 2 && i <= 11));
            if (i >= 2 && i <= 11) check("cont_disp_data", disp_data, 32'h200 + i - 2);
            check("cont_miss", disp_miss, 0);
            check("cont_host_valid", host_valid, (i == 12));
            if (i == 12) check("cont_host_data", host_data, 'hAB);
        end
`else
        // Starvation guard: host forced in at edge 5, display slot 5 repeats
        // the pixel from slot 4.
        host_addr = 17'h000CD;
        for (int i = 0; i < 12; i++) begin
            disp_req  = (i < 10);
            disp_addr = ADDR_W'(32'h300 + i);
            host_req  = (i >= 1 && i <= 5);
            step();
            check("starve_ack", host_ack, (i == 5));
            if (i < 10) check("starve_addr", bram_addr, (i == 5) ? 32'hCD : 32'h300 + i);
            check("starve_disp_valid", disp_valid, (i >= 2 && i <= 11));
            check("starve_miss", disp_miss, (i == 7));
            if (i >= 2 && i <= 11)
                check("starve_disp_data", disp_data, (i == 7) ? 32'h304 : 32'h300 + i - 2);
            check("starve_host_valid", host_valid, (i == 7));
            if (i == 7) check("starve_host_data", host_data, 'hCD);
        end
`endif

        // Out-of-range host address.
        host_addr = 17'(DEPTH);
        for (int i = 0; i < 4; i++) begin
            host_req = (i == 0);
            step();
            if (i == 0) begin
                check("oor_host_ack", host_ack, 1);
                check("oor_host_bram_addr", bram_addr, 0);
            end
            check("oor_host_valid", host_valid, (i == 2));
            if (i == 2) check("oor_host_data", host_data, 0);
        end

        // Out-of-range display address.
        disp_addr = 17'h1FFFF;
        for (int i = 0; i < 4; i++) begin
            disp_req = (i == 0);
            step();
            if (i == 0) check("oor_disp_bram_addr", bram_addr, 0);
            check("oor_disp_valid", disp_valid, (i == 2));
            if (i == 2) check("oor_disp_data", disp_data, 0);
        end

        // Completed host read so host_data is non-zero before the reset.
        host_addr = 17'h00077;
        for (int i = 0; i < 3; i++) begin
            host_req = (i == 0);
            step();
            if (i == 2) check("pre_rst_host_data", host_data, 'h77);
        end

        // Mid-operation reset one cycle after an ack.
        host_addr = 17'h00055;
        host_req  = 1'b1;
        step();
        check("rst_ack", host_ack, 1);
        host_req = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_host_valid", host_valid, 0);
            check("post_rst_disp_valid", disp_valid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
